// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: active-low glyph codes,
// FSM state encoding and the decoded-glyph record.
package seg_scan_decoder_pkg;

    // Active-low segment codes, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_ALIGN   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } glyph_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Snooped display bus (segment lines + anodes) and the decoded-word outputs.
interface seg_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   an_in;
    logic [4*DIGITS-1:0] value;
    logic                valid;
    logic                frame_err;
    logic                no_signal;
    logic [DIGITS-1:0]   blank_mask;

    modport master (
        output seg_in, an_in,
        input  value, valid, frame_err, no_signal, blank_mask
    );

    modport slave (
        input  seg_in, an_in,
        output value, valid, frame_err, no_signal, blank_mask
    );
endinterface

// File: rtl/seg_pattern_decoder.sv
// Combinational glyph lookup: 7 active-low segments -> {legal, blank, nibble}.
// SEG_DEC_BLANK_EN makes the all-off pattern a legal blank digit.
module seg_pattern_decoder
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output glyph_t     glyph
);

    // NOTE: every field is defaulted before the case so no path can infer a latch.
    always_comb begin
        glyph = '{legal: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (seg)
            SEG_0: glyph.nibble = 4'h0;
            SEG_1: glyph.nibble = 4'h1;
            SEG_2: glyph.nibble = 4'h2;
            SEG_3: glyph.nibble = 4'h3;
            SEG_4: glyph.nibble = 4'h4;
            SEG_5: glyph.nibble = 4'h5;
            SEG_6: glyph.nibble = 4'h6;
            SEG_7: glyph.nibble = 4'h7;
            SEG_8: glyph.nibble = 4'h8;
            SEG_9: glyph.nibble = 4'h9;
            SEG_A: glyph.nibble = 4'hA;
            SEG_B: glyph.nibble = 4'hB;
            SEG_C: glyph.nibble = 4'hC;
            SEG_D: glyph.nibble = 4'hD;
            SEG_E: glyph.nibble = 4'hE;
            SEG_F: glyph.nibble = 4'hF;
`ifdef SEG_DEC_BLANK_EN
            SEG_BLANK: glyph.blank = 1'b1;
`endif
            default: glyph.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and publishes the displayed hex word.
// Optional SEG_DEC_BLANK_EN (see seg_pattern_decoder) accepts blank digits.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic               clk,
    input logic               rst_n,
    seg_scan_decoder_if.slave bus
);

    localparam int              SW       = $clog2(STABLE_CYCLES);
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYCLES);

    logic [6:0]          seg_m, seg_s, seg_p;
    logic [DIGITS-1:0]   an_m, an_s, an_p;
    logic [SW-1:0]       stab_cnt;
    logic                accept;
    logic                driven, same;

    glyph_t              glyph;
    logic [DIGITS-1:0]   sel;

    state_t              state_q, state_nxt;
    logic [DIGITS-1:0]   cap_q, cap_nxt;
    logic [4*DIGITS-1:0] shadow_q, shadow_nxt;
    logic                err_q, err_nxt;
    logic [DIGITS-1:0]   blank_q, blank_nxt;
    logic                take, restart, publish;

    logic [TW-1:0]       to_cnt;
    logic [4*DIGITS-1:0] value_q;
    logic                valid_q, frame_err_q, no_signal_q;
    logic [DIGITS-1:0]   blank_mask_q;

    assign driven = $onehot(~an_s);
    assign same   = (an_s == an_p) && (seg_s == seg_p);

    // Synchroniser, previous-sample register and stability counter. The accept
    // pulse rises together with the count hitting its ceiling, so an_p/seg_p
    // hold the accepted pattern during the pulse.
    // NOTE: non-blocking assignments make the flop chain independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m    <= '1;
            seg_s    <= '1;
            seg_p    <= '1;
            an_m     <= '1;
            an_s     <= '1;
            an_p     <= '1;
            stab_cnt <= '0;
            accept   <= 1'b0;
        end else begin
            seg_m  <= bus.seg_in;
            seg_s  <= seg_m;
            seg_p  <= seg_s;
            an_m   <= bus.an_in;
            an_s   <= an_m;
            an_p   <= an_s;
            accept <= 1'b0;
            if (driven && same) begin
                if (stab_cnt != STAB_MAX) begin
                    stab_cnt <= stab_cnt + 1'b1;
                    accept   <= (stab_cnt == STAB_MAX - 1'b1);
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    assign sel = ~an_p;

    seg_pattern_decoder u_pattern (
        .seg   (seg_p),
        .glyph (glyph)
    );

    always_comb begin
        state_nxt  = state_q;
        cap_nxt    = cap_q;
        shadow_nxt = shadow_q;
        err_nxt    = err_q;
        blank_nxt  = blank_q;
        take       = 1'b0;
        restart    = 1'b0;

        case (state_q)
            ST_ALIGN: begin
                if (accept && sel[0]) begin
                    take      = 1'b1;
                    restart   = 1'b1;
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Digit 0 reappearing before the frame completes means the scan slipped.
                if (accept && sel[0]) begin
                    take    = 1'b1;
                    restart = 1'b1;
                end else if (accept && |(sel & ~cap_q)) begin
                    take = 1'b1;
                end
            end
            ST_PUBLISH: begin
                cap_nxt   = '0;
                err_nxt   = 1'b0;
                blank_nxt = '0;
                state_nxt = ST_ALIGN;
            end
            default: state_nxt = ST_ALIGN;
        endcase

        if (take) begin
            cap_nxt   = (restart ? '0 : cap_q) | sel;
            err_nxt   = (restart ? 1'b0 : err_q) | ~glyph.legal;
            blank_nxt = (restart ? '0 : blank_q) | (sel & {DIGITS{glyph.blank}});
            for (int i = 0; i < DIGITS; i++) begin
                if (sel[i]) shadow_nxt[4*i +: 4] = glyph.nibble;
            end
            if (&cap_nxt) state_nxt = ST_PUBLISH;
        end
    end

    // Outputs load on the edge into PUBLISH so valid and the new word appear together.
    assign publish = (state_nxt == ST_PUBLISH);

    // NOTE: shadow is ordinary flops rather than a RAM, so it takes the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ALIGN;
            cap_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
            blank_q  <= '0;
        end else begin
            state_q  <= state_nxt;
            cap_q    <= cap_nxt;
            shadow_q <= shadow_nxt;
            err_q    <= err_nxt;
            blank_q  <= blank_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q      <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            blank_mask_q <= '0;
            no_signal_q  <= 1'b0;
            to_cnt       <= '0;
        end else begin
            valid_q <= publish;
            if (publish) begin
                value_q      <= shadow_nxt;
                frame_err_q  <= err_nxt;
                blank_mask_q <= blank_nxt;
                no_signal_q  <= 1'b0;
                to_cnt       <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_MAX - 1'b1) no_signal_q <= 1'b1;
            end
        end
    end

    assign bus.value      = value_q;
    assign bus.valid      = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.no_signal  = no_signal_q;
    assign bus.blank_mask = blank_mask_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench for seg_scan_decoder (4 digits, short timeout).
module tb_seg_scan_decoder;

    localparam int DIGITS  = 4;
    localparam int STABLE  = 4;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic [15:0] value;
        logic        err;
        logic [3:0]  mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_decoder #(
        .DIGITS         (DIGITS),
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Independent glyph table: conventional active-high gfedcba codes, inverted.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    function automatic logic [27:0] segs_of(input logic [15:0] v);
        logic [27:0] s;
        for (int d = 0; d < 4; d++) s[7*d +: 7] = glyph(v[4*d +: 4]);
        return s;
    endfunction

    task automatic drive_digit(input int d, input logic [6:0] g, input int hold);
        bus.an_in  = 4'(~(4'b0001 << d));
        bus.seg_in = g;
        repeat (hold) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, 32'(sb.size()), 32'(0));
    endtask

    task automatic frame(input string tag, input logic [27:0] segs, input logic [15:0] v,
                         input logic e, input logic [3:0] m, input int hold);
        exp_t x;
        x.value = v;
        x.err   = e;
        x.mask  = m;
        sb.push_back(x);
        for (int d = 0; d < 4; d++) drive_digit(d, segs[7*d +: 7], hold);
        drain(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_value"},      32'(bus.value),      32'(0));
        check({tag, "_valid"},      32'(bus.valid),      32'(0));
        check({tag, "_frame_err"},  32'(bus.frame_err),  32'(0));
        check({tag, "_no_signal"},  32'(bus.no_signal),  32'(0));
        check({tag, "_blank_mask"}, 32'(bus.blank_mask), 32'(0));
    endtask

    // Monitor: every valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && bus.valid) begin
            check("valid_one_cycle", 32'(prev_valid), 32'(0));
            check("frame_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                check("value",      32'(bus.value),      32'(sb[0].value));
                check("frame_err",  32'(bus.frame_err),  32'(sb[0].err));
                check("blank_mask", 32'(bus.blank_mask), 32'(sb[0].mask));
                void'(sb.pop_front());
            end
        end
        prev_valid <= bus.valid;
    end

    initial begin
        logic [27:0] s;

        rst_n      = 1'b0;
        bus.an_in  = '1;
        bus.seg_in = '1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        frame("f321", segs_of(16'hF321), 16'hF321, 1'b0, 4'b0000, 8);

        // Digit 2 shown one sample short of acceptance: no frame ever completes.
        for (int k = 0; k < 80; k++) begin
            drive_digit(0, glyph(4'h1), 8);
            drive_digit(1, glyph(4'h2), 8);
            drive_digit(2, glyph(4'h3), STABLE - 1);
            drive_digit(3, glyph(4'hF), 8);
            if (k == 20) check("no_signal_early", 32'(bus.no_signal), 32'(0));
        end
        check("no_signal_set", 32'(bus.no_signal), 32'(1));
        check("value_held", 32'(bus.value), 32'(16'hF321));
        frame("recover", segs_of(16'h7654), 16'h7654, 1'b0, 4'b0000, 8);
        check("no_signal_clear", 32'(bus.no_signal), 32'(0));

        s = segs_of(16'h0C08);
        s[13:7] = 7'b1010101;
        frame("illegal", s, 16'h0C08, 1'b1, 4'b0000, 8);
        frame("clean_after_err", segs_of(16'hDBA9), 16'hDBA9, 1'b0, 4'b0000, 8);

        // Two anodes low between digits must not disturb the frame.
        begin
            exp_t x;
            x.value = 16'h526E;
            x.err   = 1'b0;
            x.mask  = 4'b0000;
            sb.push_back(x);
            drive_digit(0, glyph(4'hE), 8);
            bus.an_in  = 4'b1100;
            bus.seg_in = glyph(4'h5);
            repeat (20) @(negedge clk);
            drive_digit(1, glyph(4'h6), 8);
            drive_digit(2, glyph(4'h2), 8);
            drive_digit(3, glyph(4'h5), 8);
            drain("two_low");
        end

        frame("hold_min", segs_of(16'hBEAD), 16'hBEAD, 1'b0, 4'b0000, STABLE);

        drive_digit(2, glyph(4'h7), 8);
        drive_digit(3, glyph(4'h7), 8);
        frame("start_mid", segs_of(16'hEF01), 16'hEF01, 1'b0, 4'b0000, 8);

        s = segs_of(16'h0321);
        s[27:21] = 7'h7F;
`ifdef SEG_DEC_BLANK_EN
        frame("blank", s, 16'h0321, 1'b0, 4'b1000, 8);
`else
        frame("blank", s, 16'h0321, 1'b1, 4'b0000, 8);
`endif

        drive_digit(0, glyph(4'h9), 8);
        drive_digit(1, glyph(4'h9), 8);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame("after_reset", segs_of(16'h2468), 16'h2468, 1'b0, 4'b0000, 8);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
